// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions: the four response codes returned on the
// B and R channels.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_reg_bank.sv
// AXI-lite register bank.
//
// Provides REG_COUNT registers of DATA_WIDTH bits, each written through
// AXI-lite with byte strobes. All registers are exported flat on reg_out,
// and reg_wr gives a one-cycle pulse per register on every committed write.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   axil_aw*/w*/b*  AXI-lite write address, write data and write response
//   axil_ar*/r*     AXI-lite read address and read data
//   reg_out         register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr          per-register commit pulse
//
// Build option: define AXIL_REG_BANK_DECERR_EN to answer out-of-range
// accesses with DECERR. When it is undefined they answer OKAY. In both
// cases the write is dropped and the read returns zero.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            axil_awaddr,
  input  logic [2:0]                       axil_awprot,
  input  logic                             axil_awvalid,
  output logic                             axil_awready,
  input  logic [DATA_WIDTH-1:0]            axil_wdata,
  input  logic [STRB_WIDTH-1:0]            axil_wstrb,
  input  logic                             axil_wvalid,
  output logic                             axil_wready,
  output logic [1:0]                       axil_bresp,
  output logic                             axil_bvalid,
  input  logic                             axil_bready,
  input  logic [ADDR_WIDTH-1:0]            axil_araddr,
  input  logic [2:0]                       axil_arprot,
  input  logic                             axil_arvalid,
  output logic                             axil_arready,
  output logic [DATA_WIDTH-1:0]            axil_rdata,
  output logic [1:0]                       axil_rresp,
  output logic                             axil_rvalid,
  input  logic                             axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_out,
  output logic [REG_COUNT-1:0]             reg_wr
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

`ifdef AXIL_REG_BANK_DECERR_EN
  localparam logic [1:0] RESP_OOR = RESP_DECERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_fire, w_fire, ar_fire, commit;
  logic                  aw_in_range, ar_in_range;
  logic [DATA_WIDTH-1:0] rd_value;

  // Protection bits and sub-word address bits carry no meaning here.
  wire unused_ok = ^{axil_awprot, axil_arprot,
                     axil_awaddr[ADDR_LSB-1:0], axil_araddr[ADDR_LSB-1:0]};

  // Ready is held low while in reset so no handshake can land on a reset edge.
  assign axil_awready = !rst && !aw_held && !axil_bvalid;
  assign axil_wready  = !rst && !w_held && !axil_bvalid;
  assign axil_arready = !rst && !axil_rvalid;

  assign aw_fire = axil_awvalid && axil_awready;
  assign w_fire  = axil_wvalid && axil_wready;
  assign ar_fire = axil_arvalid && axil_arready;
  assign commit  = aw_held && w_held && !axil_bvalid;

  assign ar_idx      = axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_in_range = int'(aw_idx) < REG_COUNT;
  assign ar_in_range = int'(ar_idx) < REG_COUNT;

  // The register array is sampled before this edge's commit, so a read that
  // coincides with a write to the same register returns the old contents.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (ar_idx == IDX_W'(i)) rd_value = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      aw_held     <= 1'b0;
      aw_idx      <= '0;
      w_held      <= 1'b0;
      w_data      <= '0;
      w_strb      <= '0;
      axil_bvalid <= 1'b0;
      axil_bresp  <= RESP_OKAY;
      axil_rvalid <= 1'b0;
      axil_rresp  <= RESP_OKAY;
      axil_rdata  <= '0;
      reg_wr      <= '0;
    end else begin
      reg_wr <= '0;

      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= axil_wdata;
        w_strb <= axil_wstrb;
      end

      if (commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        axil_bvalid <= 1'b1;
        axil_bresp  <= aw_in_range ? RESP_OKAY : RESP_OOR;
        for (int i = 0; i < REG_COUNT; i++) begin
          if (aw_idx == IDX_W'(i)) begin
            reg_wr[i] <= 1'b1;
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end else if (axil_bvalid && axil_bready) begin
        axil_bvalid <= 1'b0;
      end

      if (ar_fire) begin
        axil_rvalid <= 1'b1;
        axil_rdata  <= rd_value;
        axil_rresp  <= ar_in_range ? RESP_OKAY : RESP_OOR;
      end else if (axil_rvalid && axil_rready) begin
        axil_rvalid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-lite data width (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte strobe width.
REQ-004 SHALL have parameter REG_COUNT, default 16, number of registers (1..2^(ADDR_WIDTH-log2(STRB_WIDTH))).
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports SHALL be: clk input 1 clock; rst input 1 reset.
REQ-006 SHALL have AXI-lite write ports: axil_awaddr in ADDR_WIDTH; axil_awprot in 3; axil_awvalid in 1; axil_awready out 1; axil_wdata in DATA_WIDTH; axil_wstrb in STRB_WIDTH; axil_wvalid in 1; axil_wready out 1; axil_bresp out 2; axil_bvalid out 1; axil_bready in 1.
REQ-007 SHALL have AXI-lite read ports: axil_araddr in ADDR_WIDTH; axil_arprot in 3; axil_arvalid in 1; axil_arready out 1; axil_rdata out DATA_WIDTH; axil_rresp out 2; axil_rvalid out 1; axil_rready in 1.
REQ-008 SHALL have reg_out output REG_COUNT*DATA_WIDTH, flat register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have reg_wr output REG_COUNT, one-cycle pulse per register on committed write.

Function
REQ-010 Register index SHALL be addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low address bits ignored; awprot/arprot ignored.
REQ-011 axil_awready SHALL be high iff no AW held and axil_bvalid low; axil_wready likewise for W; AW and W accepted independently, either order or same cycle.
REQ-012 Write commit SHALL occur on the edge after both AW and W are held with bvalid low: byte lanes with wstrb=1 updated, reg_wr[index] pulsed for that cycle, bvalid set, held flags cleared.
REQ-013 Latency: AW+W handshake same edge N -> register, reg_wr and bvalid visible after edge N+1.
REQ-014 axil_bvalid and axil_bresp SHALL hold until axil_bready handshake; bvalid clears on that edge.
REQ-015 axil_arready SHALL equal !axil_rvalid; AR handshake at edge N loads rdata/rresp and sets rvalid after edge N (latency 1).
REQ-016 axil_rdata/axil_rresp SHALL hold stable while rvalid high and rready low.
REQ-017 Simultaneous read and commit to same register SHALL return pre-write value.
REQ-018 wstrb all-zero SHALL complete with OKAY, no data change, reg_wr still pulsed.
REQ-019 In-range accesses SHALL respond OKAY (2'b00).
REQ-020 Out-of-range index (>= REG_COUNT): write discarded, no reg_wr pulse; read data zero; response per REQ-024.

Reset
REQ-021 On rst all registers SHALL be 0, reg_wr 0, held flags cleared.
REQ-022 On rst axil_awready, axil_wready, axil_arready SHALL be 0 during reset and 1 the cycle after; bvalid, rvalid 0; bresp, rresp, rdata 0.
REQ-023 Reset mid-transaction SHALL drop held AW/W and pending B/R responses without committing.

Configuration
REQ-024 Macro AXIL_REG_BANK_DECERR_EN: defined -> out-of-range accesses respond DECERR (2'b11); undefined -> respond OKAY; data behaviour per REQ-020 in both cases.

Structure
REQ-025 Shared package axil_pkg SHALL hold response-code constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11).
REQ-026 No sub-module; write and read channel logic inline.

Verification
REQ-027 Write 0xDEADBEEF, wstrb 0xF, addr 0x0008 (AW and W same cycle) -> bvalid 2 edges later, bresp OKAY, reg_out reg2 = 0xDEADBEEF, reg_wr = 0x0004 one cycle.
REQ-028 W at edge N, AW at N+3, addr 0x0004, wdata 0x12345678, wstrb 0x3 onto 0xFFFFFFFF -> reg1 = 0xFFFF5678, bresp OKAY.
REQ-029 Read addr 0x0008 with rready held low 5 cycles -> rvalid held, rdata 0xDEADBEEF stable, arready low until R handshake.
REQ-030 Write/read addr 0x0100 (REG_COUNT 16) -> no register change, rdata 0; resp 2'b11 with AXIL_REG_BANK_DECERR_EN, 2'b00 without.
REQ-031 Same-edge commit of 0x1 and read of reg0 holding 0x0 -> rdata 0x0; subsequent read 0x1.
REQ-032 Assert rst while bvalid pending and AW held -> bvalid 0, no later commit, all registers 0.
